// File: rtl/pattern_serializer_if.sv
// Serial pattern source bus: request side (pattern/len/repeat/start/abort)
// and the registered serial stream plus status pulses.
interface pattern_serializer_if #(
   parameter int W     = 8,
   parameter int LEN_W = 4,
   parameter int RPT_W = 4
);
   logic             start;
   logic [W-1:0]     pattern;
   logic [LEN_W-1:0] len;
   logic [RPT_W-1:0] repeat_n;
   logic             abort;
   logic             ser_out;
   logic             ser_vld;
   logic             busy;
   logic             frame_end;
   logic             done;

   modport master (
      output start, pattern, len, repeat_n, abort,
      input  ser_out, ser_vld, busy, frame_end, done
   );

   modport slave (
      input  start, pattern, len, repeat_n, abort,
      output ser_out, ser_vld, busy, frame_end, done
   );
endinterface

// File: rtl/pattern_serializer.sv
// MSB-first bit-serial pattern transmitter with back-to-back frame repeat.
// Optional SERIAL_PARITY_EN appends an even-parity bit to every frame.
module pattern_serializer #(
   parameter int W     = 8,
   parameter int LEN_W = 4,
   parameter int RPT_W = 4
) (
   input logic               clk,
   input logic               rst,
   pattern_serializer_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] PAR   = 2'd2;

`ifdef SERIAL_PARITY_EN
   localparam logic DATA_ENDS_FRAME = 1'b0;
`else
   localparam logic DATA_ENDS_FRAME = 1'b1;
`endif

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     pat_q, pat_d;   // latched pattern, left-aligned to MSB
   logic [W-1:0]     sh_q, sh_d;     // bits still to send in this frame
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;   // bits remaining after the one on ser_out
   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_vld_q, ser_vld_d;
   logic             frame_end_q, frame_end_d;
   logic             done_q, done_d;
`ifdef SERIAL_PARITY_EN
   logic             par_q, par_d;
`endif

   logic [W-1:0]     aligned;
   logic             len_ok;
   logic             frame_over;

   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      sh_d        = sh_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      rpt_d       = rpt_q;
      ser_out_d   = 1'b0;
      ser_vld_d   = 1'b0;
      frame_end_d = 1'b0;
      done_d      = 1'b0;
      frame_over  = 1'b0;
`ifdef SERIAL_PARITY_EN
      par_d       = par_q;
`endif
      // Shifting left by W-len drops the unused upper bits of the pattern.
      aligned = bus.pattern << (LEN_W'(W) - bus.len);
      len_ok  = (bus.len != '0) && (bus.len <= LEN_W'(W));

      case (state_q)
         IDLE: begin
            if (bus.start && len_ok) begin
               state_d     = SHIFT;
               pat_d       = aligned;
               len_d       = bus.len;
               rpt_d       = bus.repeat_n;
               ser_out_d   = aligned[W-1];
               ser_vld_d   = 1'b1;
               sh_d        = aligned << 1;
               cnt_d       = bus.len - 1'b1;
               frame_end_d = DATA_ENDS_FRAME && (bus.len == LEN_W'(1));
`ifdef SERIAL_PARITY_EN
               par_d       = ^aligned;
`endif
            end
         end
         SHIFT: begin
            if (bus.abort) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (cnt_q != '0) begin
               ser_out_d   = sh_q[W-1];
               ser_vld_d   = 1'b1;
               sh_d        = sh_q << 1;
               cnt_d       = cnt_q - 1'b1;
               frame_end_d = DATA_ENDS_FRAME && (cnt_q == LEN_W'(1));
            end else begin
`ifdef SERIAL_PARITY_EN
               state_d     = PAR;
               ser_out_d   = par_q;
               ser_vld_d   = 1'b1;
               frame_end_d = 1'b1;
`else
               frame_over  = 1'b1;
`endif
            end
         end
`ifdef SERIAL_PARITY_EN
         PAR: begin
            if (bus.abort) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               frame_over = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      // End of a frame: reload the latched pattern or finish.
      if (frame_over) begin
         if (rpt_q != '0) begin
            state_d     = SHIFT;
            rpt_d       = rpt_q - 1'b1;
            ser_out_d   = pat_q[W-1];
            ser_vld_d   = 1'b1;
            sh_d        = pat_q << 1;
            cnt_d       = len_q - 1'b1;
            frame_end_d = DATA_ENDS_FRAME && (len_q == LEN_W'(1));
         end else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pat_q       <= '0;
         sh_q        <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         rpt_q       <= '0;
         ser_out_q   <= 1'b0;
         ser_vld_q   <= 1'b0;
         frame_end_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef SERIAL_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         sh_q        <= sh_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         rpt_q       <= rpt_d;
         ser_out_q   <= ser_out_d;
         ser_vld_q   <= ser_vld_d;
         frame_end_q <= frame_end_d;
         done_q      <= done_d;
`ifdef SERIAL_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign bus.ser_out   = ser_out_q;
   assign bus.ser_vld   = ser_vld_q;
   assign bus.frame_end = frame_end_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_pattern_serializer.sv
// Randomized bench for pattern_serializer: an expected per-cycle output stream
// is built from frame/bit arithmetic and compared cycle by cycle.
module tb_pattern_serializer;
   localparam int W     = 8;
   localparam int LEN_W = 4;
   localparam int RPT_W = 4;
`ifdef SERIAL_PARITY_EN
   localparam bit PARITY = 1'b1;
`else
   localparam bit PARITY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pattern_serializer_if #(.W(W), .LEN_W(LEN_W), .RPT_W(RPT_W)) bus ();

   pattern_serializer #(.W(W), .LEN_W(LEN_W), .RPT_W(RPT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;
   // Entry layout: {busy, ser_vld, ser_out, frame_end, done}
   logic [4:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] obs_vec();
      return {bus.busy, bus.ser_vld, bus.ser_out, bus.frame_end, bus.done};
   endfunction

   // Reference: every frame sends p[len-1..0] (then parity), frames repeat
   // rpt extra times, then one done cycle.
   task automatic gen_exp(input logic [W-1:0] p, input int len, input int rpt);
      logic par;
      exp_q.delete();
      par = 1'b0;
      for (int b = 0; b < len; b++) par ^= p[b];
      for (int f = 0; f <= rpt; f++) begin
         for (int b = len - 1; b >= 0; b--)
            exp_q.push_back({1'b1, 1'b1, p[b], (b == 0) && !PARITY, 1'b0});
         if (PARITY) exp_q.push_back({1'b1, 1'b1, par, 1'b1, 1'b0});
      end
      exp_q.push_back(5'b00001);
   endtask

   task automatic run(input string name, input logic [W-1:0] p, input int len,
                      input int rpt, input int abort_at, input int rst_at,
                      input bit hold, input bit idle_after);
      int nv;
      bit last;
      gen_exp(p, len, rpt);
      nv = exp_q.size() - 1;
      if (abort_at > 0 && abort_at <= nv) begin
         while (exp_q.size() > abort_at) void'(exp_q.pop_back());
         exp_q.push_back(5'b00001);
      end else if (rst_at > 0 && rst_at <= nv) begin
         while (exp_q.size() > rst_at) void'(exp_q.pop_back());
         exp_q.push_back(5'b00000);
      end
      bus.start    = 1'b1;
      bus.pattern  = p;
      bus.len      = LEN_W'(len);
      bus.repeat_n = RPT_W'(rpt);
      bus.abort    = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("%s[%0d]", name, i), 32'(obs_vec()), 32'(exp_q[i]));
         last = (i == exp_q.size() - 1);
         // Scramble request inputs while busy; they must have no effect.
         bus.start    = hold && !last;
         bus.pattern  = W'($urandom);
         bus.len      = LEN_W'($urandom);
         bus.repeat_n = RPT_W'($urandom);
         bus.abort    = !last && (i + 1 == abort_at);
         rst          = !last && (i + 1 == rst_at);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst       = 1'b0;
      if (idle_after) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("%s_idle", name), 32'(obs_vec()), 32'd0);
      end
   endtask

   task automatic bad_start(input string name, input int len);
      bus.start = 1'b1;
      bus.len   = LEN_W'(len);
      bus.pattern = W'($urandom);
      bus.abort = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("%s[%0d]", name, i), 32'(obs_vec()), 32'd0);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   initial begin
      int len, rpt, nv, ab, rs;
      bus.start    = 1'b0;
      bus.pattern  = '0;
      bus.len      = '0;
      bus.repeat_n = '0;
      bus.abort    = 1'b0;
      rst          = 1'b1;
      bus.start    = 1'b1;
      bus.len      = LEN_W'(4);
      @(posedge clk);
      @(negedge clk);
      chk("reset", 32'(obs_vec()), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("reset_hold", 32'(obs_vec()), 32'd0);
      bus.start = 1'b0;
      rst       = 1'b0;
      @(negedge clk);

      run("p0d",    8'h0D,       4, 0, 0, 0, 0, 1);
      run("rpt2",   8'h0D,       4, 2, 0, 0, 0, 1);
      run("ovl7",   8'b01101101, 7, 0, 0, 0, 0, 1);
      run("hold",   8'hA5,       8, 1, 0, 0, 1, 1);
      bad_start("len0", 0);
      bad_start("len9", 9);
      bad_start("len15", 15);
      run("abort2", 8'h0D,       4, 0, 2, 0, 1, 1);
      run("rst3",   8'h0D,       4, 0, 0, 3, 0, 1);
      run("b2b_a",  8'h0D,       4, 0, 0, 0, 0, 0);
      run("b2b_b",  8'hC3,       8, 0, 0, 0, 0, 1);
      run("par1001", 8'h09,      4, 0, 0, 0, 0, 1);
      run("len1",   8'h01,       1, 3, 0, 0, 0, 1);
      run("rptmax", 8'h02,       2, 15, 0, 0, 0, 1);

      for (int t = 0; t < 30; t++) begin
         len = $urandom_range(1, W);
         rpt = $urandom_range(0, 3);
         nv  = (len + int'(PARITY)) * (rpt + 1);
         ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nv) : 0;
         rs  = (ab == 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, nv) : 0;
         run($sformatf("rnd%0d", t), W'($urandom), len, rpt, ab, rs,
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
